// File: rtl/radix2_stage_ctrl_pkg.sv
// Shared constants, FSM encoding and butterfly address math for the
// radix-2 DIF FFT stage controllers.
package radix2_stage_ctrl_pkg;

  localparam int LOG2N    = 7;
  localparam int N        = 1 << LOG2N;
  localparam int TW_AW    = 6;
  localparam int PIPE_LAT = 3;
  localparam int KW       = LOG2N - 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  typedef struct packed {
    logic [LOG2N-1:0] a;
    logic [LOG2N-1:0] b;
    logic [TW_AW-1:0] tw;
  } bfly_addr_t;

  // With half = N >> (s+1): j = k mod half and g = k / half reduce to a
  // mask and a shift because half is always a power of two.
  function automatic bfly_addr_t bfly_addr(input logic [KW-1:0] k, input logic [2:0] s);
    bfly_addr_t       r;
    int               sh;
    logic [LOG2N-1:0] kx;
    logic [LOG2N-1:0] half;
    logic [LOG2N-1:0] mask;
    logic [LOG2N-1:0] j;
    logic [LOG2N-1:0] g;
    sh   = LOG2N - 1 - int'(s);
    kx   = {1'b0, k};
    half = {{(LOG2N-1){1'b0}}, 1'b1} << sh;
    mask = half - {{(LOG2N-1){1'b0}}, 1'b1};
    j    = kx & mask;
    g    = kx >> sh;
    r.a  = (g << (sh + 1)) | j;
    r.b  = r.a | half;
    r.tw = TW_AW'(j << s);
    return r;
  endfunction

endpackage

// File: rtl/radix2_stage_ctrl_valid_delay.sv
// fft_valid_delay: fixed-depth shift register carrying a valid flag and an
// address pair, aligning write-back with the butterfly datapath latency.
module fft_valid_delay #(
  parameter int DEPTH = 3,
  parameter int AW    = 7
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          valid_i,
  input  logic [AW-1:0] addr_a_i,
  input  logic [AW-1:0] addr_b_i,
  output logic          valid_o,
  output logic [AW-1:0] addr_a_o,
  output logic [AW-1:0] addr_b_o,
  output logic          drained_o
);

  logic [DEPTH-1:0]         valid_q;
  logic [DEPTH-1:0]         valid_d;
  logic [DEPTH-1:0][AW-1:0] addr_a_q;
  logic [DEPTH-1:0][AW-1:0] addr_b_q;

  // Next valid vector; drained_o looks ahead so the caller can finish on
  // the same edge the last valid leaves the output register.
  always_comb begin
    valid_d    = {DEPTH{1'b0}};
    valid_d[0] = valid_i;
    for (int i = 1; i < DEPTH; i++) begin
      valid_d[i] = valid_q[i-1];
    end
  end

  assign drained_o = ~|valid_d;

  // Shift every cycle; upstream stalls simply become bubbles.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q  <= {DEPTH{1'b0}};
      addr_a_q <= {(DEPTH*AW){1'b0}};
      addr_b_q <= {(DEPTH*AW){1'b0}};
    end else begin
      valid_q     <= valid_d;
      addr_a_q[0] <= addr_a_i;
      addr_b_q[0] <= addr_b_i;
      for (int i = 1; i < DEPTH; i++) begin
        addr_a_q[i] <= addr_a_q[i-1];
        addr_b_q[i] <= addr_b_q[i-1];
      end
    end
  end

  assign valid_o  = valid_q[DEPTH-1];
  assign addr_a_o = addr_a_q[DEPTH-1];
  assign addr_b_o = addr_b_q[DEPTH-1];

endmodule

// File: rtl/radix2_stage_ctrl.sv
// Radix-2 DIF stage sequencer: issues N/2 butterfly read/twiddle addresses
// and a latency-matched write-back stream, then reports done.
module radix2_stage_ctrl
  import radix2_stage_ctrl_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [2:0]       stage_i,
  input  logic             hold_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic             rd_en_o,
  output logic [LOG2N-1:0] rd_addr_a_o,
  output logic [LOG2N-1:0] rd_addr_b_o,
  output logic [TW_AW-1:0] tw_addr_o,
  output logic             wb_valid_o,
  output logic [LOG2N-1:0] wb_addr_a_o,
  output logic [LOG2N-1:0] wb_addr_b_o
);

  localparam logic [KW-1:0] K_LAST = KW'(N / 2 - 1);

  state_e           state_q;
  logic [2:0]       stage_q;
  logic [KW-1:0]    k_q;
  logic             busy_q;
  logic             done_q;
  logic             err_q;
  logic             rd_en_q;
  logic [LOG2N-1:0] rd_addr_a_q;
  logic [LOG2N-1:0] rd_addr_b_q;
  logic [TW_AW-1:0] tw_addr_q;
  bfly_addr_t       bfly_d;
  logic             dl_drained_d;

  // Addresses of the butterfly that would be issued this cycle.
  always_comb begin
    bfly_d = bfly_addr(k_q, stage_q);
  end

  // Stage FSM with registered outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      stage_q     <= 3'd0;
      k_q         <= {KW{1'b0}};
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      rd_en_q     <= 1'b0;
      rd_addr_a_q <= {LOG2N{1'b0}};
      rd_addr_b_q <= {LOG2N{1'b0}};
      tw_addr_q   <= {TW_AW{1'b0}};
    end else begin
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rd_en_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          busy_q <= 1'b0;
          if (start_i) begin
            if ({1'b0, stage_i} < 4'(LOG2N)) begin
              stage_q <= stage_i;
              k_q     <= {KW{1'b0}};
              busy_q  <= 1'b1;
              state_q <= ST_RUN;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (!hold_i) begin
            rd_en_q     <= 1'b1;
            rd_addr_a_q <= bfly_d.a;
            rd_addr_b_q <= bfly_d.b;
            tw_addr_q   <= bfly_d.tw;
            k_q         <= k_q + {{(KW-1){1'b0}}, 1'b1};
            if (k_q == K_LAST) begin
              state_q <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (dl_drained_d) begin
            done_q  <= 1'b1;
            state_q <= ST_IDLE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  fft_valid_delay #(
    .DEPTH (PIPE_LAT),
    .AW    (LOG2N)
  ) u_wb_delay (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .valid_i   (rd_en_q),
    .addr_a_i  (rd_addr_a_q),
    .addr_b_i  (rd_addr_b_q),
    .valid_o   (wb_valid_o),
    .addr_a_o  (wb_addr_a_o),
    .addr_b_o  (wb_addr_b_o),
    .drained_o (dl_drained_d)
  );

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign rd_en_o     = rd_en_q;
  assign rd_addr_a_o = rd_addr_a_q;
  assign rd_addr_b_o = rd_addr_b_q;
  assign tw_addr_o   = tw_addr_q;

endmodule

// File: tb/tb_radix2_stage_ctrl.sv
// Scoreboard bench for radix2_stage_ctrl: expected read and write-back
// streams are queued at start and consumed as the DUT emits them.
module tb_radix2_stage_ctrl;
  import radix2_stage_ctrl_pkg::*;

  typedef struct {
    int a;
    int b;
    int tw;
  } exp_t;

  logic             clk;
  logic             rst_i;
  logic             start_i;
  logic [2:0]       stage_i;
  logic             hold_i;
  logic             busy_o;
  logic             done_o;
  logic             err_o;
  logic             rd_en_o;
  logic [LOG2N-1:0] rd_addr_a_o;
  logic [LOG2N-1:0] rd_addr_b_o;
  logic [TW_AW-1:0] tw_addr_o;
  logic             wb_valid_o;
  logic [LOG2N-1:0] wb_addr_a_o;
  logic [LOG2N-1:0] wb_addr_b_o;

  exp_t rd_q[$];
  exp_t wb_q[$];
  int   n_vec;
  int   n_miss;
  int   rd_seen;
  int   wb_seen;

  radix2_stage_ctrl dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .stage_i     (stage_i),
    .hold_i      (hold_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .err_o       (err_o),
    .rd_en_o     (rd_en_o),
    .rd_addr_a_o (rd_addr_a_o),
    .rd_addr_b_o (rd_addr_b_o),
    .tw_addr_o   (tw_addr_o),
    .wb_valid_o  (wb_valid_o),
    .wb_addr_a_o (wb_addr_a_o),
    .wb_addr_b_o (wb_addr_b_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic push_expect(input int s);
    int half, j, g, a;
    exp_t e;
    half = N >> (s + 1);
    for (int k = 0; k < N / 2; k++) begin
      j    = k % half;
      g    = k / half;
      a    = g * 2 * half + j;
      e.a  = a;
      e.b  = a + half;
      e.tw = (j << s) % (N / 2);
      rd_q.push_back(e);
      wb_q.push_back(e);
    end
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_busy"}, 32'(busy_o), 32'd0);
    chk({tag, "_done"}, 32'(done_o), 32'd0);
    chk({tag, "_err"}, 32'(err_o), 32'd0);
    chk({tag, "_rd_en"}, 32'(rd_en_o), 32'd0);
    chk({tag, "_rd_addr"}, 32'({rd_addr_a_o, rd_addr_b_o, tw_addr_o}), 32'd0);
    chk({tag, "_wb"}, 32'({wb_valid_o, wb_addr_a_o, wb_addr_b_o}), 32'd0);
  endtask

  // Scoreboard: every issued read and every write-back must match the next
  // queued expectation, in order.
  always @(negedge clk) begin
    exp_t e;
    if (rd_en_o) begin
      rd_seen++;
      if (rd_q.size() == 0) begin
        chk("rd_unexpected", 32'(rd_en_o), 32'd0);
      end else begin
        e = rd_q.pop_front();
        chk("rd_addr_a", 32'(rd_addr_a_o), e.a);
        chk("rd_addr_b", 32'(rd_addr_b_o), e.b);
        chk("tw_addr", 32'(tw_addr_o), e.tw);
      end
    end
    if (wb_valid_o) begin
      wb_seen++;
      if (wb_q.size() == 0) begin
        chk("wb_unexpected", 32'(wb_valid_o), 32'd0);
      end else begin
        e = wb_q.pop_front();
        chk("wb_addr_a", 32'(wb_addr_a_o), e.a);
        chk("wb_addr_b", 32'(wb_addr_b_o), e.b);
      end
    end
  end

  // Cycle r is observed at the negedge after edge r; edge 0 accepts start.
  task automatic run_stage(input int s, input int hs, input int hl, input int exp_done,
                           input int restart_at, input int rst_at);
    int done_at;
    done_at = -1;
    @(negedge clk);
    start_i = 1'b1;
    stage_i = 3'(s);
    hold_i  = 1'b0;
    rd_seen = 0;
    wb_seen = 0;
    push_expect(s);
    @(posedge clk);
    for (int r = 0; r < 200; r++) begin
      @(negedge clk);
      start_i = 1'b0;
      if (r == 0) chk("busy_after_start", 32'(busy_o), 32'd1);
      if (rst_at > 0 && r == rst_at) begin
        check_quiet("rst_mid");
        break;
      end
      if (r >= hs && r < hs + hl) chk("hold_rd_gap", 32'(rd_en_o), 32'd0);
      if (r >= hs + PIPE_LAT && r < hs + hl + PIPE_LAT) chk("hold_wb_gap", 32'(wb_valid_o), 32'd0);
      if (s == 0 && hl == 0 && r == 6) chk("s0_k5", 32'({rd_addr_a_o, rd_addr_b_o, tw_addr_o}), {13'd0, 7'd5, 7'd69, 6'd5});
      if (s == 6 && r == 4) chk("s6_k3", 32'({rd_addr_a_o, rd_addr_b_o, tw_addr_o}), {13'd0, 7'd6, 7'd7, 6'd0});
      if (s == 2 && r == 18) chk("s2_k17", 32'({rd_addr_a_o, rd_addr_b_o, tw_addr_o}), {13'd0, 7'd33, 7'd49, 6'd4});
      if (restart_at > 0 && r == restart_at) chk("restart_no_err", 32'(err_o), 32'd0);
      if (done_o) begin
        done_at = r;
        chk("busy_in_done", 32'(busy_o), 32'd1);
      end
      if (done_at >= 0 && r == done_at + 1) begin
        chk("busy_clear", 32'(busy_o), 32'd0);
        break;
      end
      hold_i = ((r + 1) >= hs) && ((r + 1) < hs + hl);
      if (restart_at > 0 && r + 1 == restart_at) begin
        start_i = 1'b1;
        stage_i = 3'd5;
      end
      if (rst_at > 0 && r + 1 == rst_at) rst_i = 1'b1;
    end
    hold_i = 1'b0;
    if (rst_at > 0) begin
      rd_q.delete();
      wb_q.delete();
      repeat (2) @(negedge clk);
      rst_i = 1'b0;
      for (int i = 0; i < 6; i++) begin
        @(negedge clk);
        check_quiet("post_rst");
      end
    end else begin
      chk("done_cycle", 32'(done_at), 32'(exp_done));
      chk("rd_count", 32'(rd_seen), 32'd64);
      chk("wb_count", 32'(wb_seen), 32'd64);
      chk("rd_q_empty", 32'(rd_q.size()), 32'd0);
      chk("wb_q_empty", 32'(wb_q.size()), 32'd0);
    end
  endtask

  initial begin
    n_vec   = 0;
    n_miss  = 0;
    rd_seen = 0;
    wb_seen = 0;
    rst_i   = 1'b1;
    start_i = 1'b0;
    stage_i = 3'd0;
    hold_i  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_quiet("reset");
    rst_i = 1'b0;

    run_stage(0, 0, 0, 68, 0, 0);
    run_stage(6, 0, 0, 68, 0, 0);
    run_stage(2, 0, 0, 68, 0, 0);
    run_stage(0, 10, 5, 73, 0, 0);

    @(negedge clk);
    start_i = 1'b1;
    stage_i = 3'd7;
    @(posedge clk);
    @(negedge clk);
    start_i = 1'b0;
    chk("err_pulse", 32'(err_o), 32'd1);
    chk("err_busy", 32'(busy_o), 32'd0);
    @(negedge clk);
    chk("err_one_cycle", 32'(err_o), 32'd0);
    chk("err_busy_after", 32'(busy_o), 32'd0);

    run_stage(1, 0, 0, 68, 30, 0);
    run_stage(3, 0, 0, 68, 0, 20);
    run_stage(3, 0, 0, 68, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
